// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port.
// One transaction at a time, data-first priority, with a fetch anti-starvation
// streak counter.
// Ports: i_* fetch requester, d_* data requester, mem_* memory side,
// stall = combinational pipeline hold while any requester is unserved.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [SW-1:0]     streak_q, streak_d;

  logic data_pend;
  logic fetch_starved;

  assign data_pend     = d_re | d_we;
  assign fetch_starved = i_req & (streak_q == STREAK_MAX);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    streak_d    = streak_q;

    unique case (state_q)
      IDLE: begin
        if (data_pend && !fetch_starved) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          // d_re & d_we together is resolved as a store
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (i_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end else if (i_req) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          streak_d   = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_ack_d   = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      streak_q    <= streak_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (i_req & ~i_ack_q) | (data_pend & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_re, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_re     (d_re),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall    (stall)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the memory, what was granted,
  // and how many data grants fetch has sat through.
  int          m_busy;      // 0 none, 1 fetch, 2 data
  logic        m_req, m_we, m_iack, m_dack;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  int          m_streak;
  int          wait_cnt;

  // stimulus knobs
  int p_i, p_d, p_both, p_spur;
  bit b2b, fixed1, rel_rst;

  task automatic model_reset();
    m_busy = 0; m_req = 0; m_we = 0; m_iack = 0; m_dack = 0;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    m_streak = 0; wait_cnt = 0;
  endtask

  task automatic model_update();
    m_iack = 0;
    m_dack = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_busy == 0) begin
      if ((d_re | d_we) && !(i_req && m_streak == SMAX)) begin
        m_busy  = 2;
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_streak = i_req ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
      end else if (i_req) begin
        m_busy   = 1;
        m_we     = 0;
        m_addr   = i_addr;
        m_streak = 0;
      end
      if (m_busy != 0) wait_cnt = fixed1 ? 2 : int'($urandom_range(0, 2));
    end else if (mem_ready) begin
      if (m_busy == 1) begin
        m_iack   = 1;
        m_irdata = mem_rdata;
      end else begin
        m_dack = 1;
        if (!m_we) m_drdata = mem_rdata;
      end
      m_busy = 0;
    end
    m_req = (m_busy != 0);
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "mem_req"},   32'(mem_req),   32'(m_req));
    check({pfx, "mem_we"},    32'(mem_we),    32'(m_we));
    check({pfx, "mem_addr"},  mem_addr,       m_addr);
    check({pfx, "mem_wdata"}, mem_wdata,      m_wdata);
    check({pfx, "i_ack"},     32'(i_ack),     32'(m_iack));
    check({pfx, "d_ack"},     32'(d_ack),     32'(m_dack));
    check({pfx, "i_rdata"},   i_rdata,        m_irdata);
    check({pfx, "d_rdata"},   d_rdata,        m_drdata);
  endtask

  task automatic new_data_req();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < p_both) begin
      d_re = 1; d_we = 1;
    end else if (r[0]) begin
      d_re = 1; d_we = 0;
    end else begin
      d_re = 0; d_we = 1;
    end
    d_addr  = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    d_wdata = $urandom;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs("");
    // requesters: drop in the ack cycle, otherwise maybe raise a new request
    if (m_iack) begin
      i_req = 0;
    end else if (!i_req && int'($urandom_range(0, 99)) < p_i) begin
      i_req  = 1;
      i_addr = fixed1 ? 32'h40 : {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    end
    if (m_dack && !b2b) begin
      d_re = 0; d_we = 0;
    end else if (m_dack || (!(d_re | d_we) && int'($urandom_range(0, 99)) < p_d)) begin
      new_data_req();
    end
    // memory responder
    mem_ready = 0;
    if (m_req) begin
      if (wait_cnt == 0) begin
        mem_ready = 1;
        mem_rdata = fixed1 ? 32'h0050_0093 : $urandom;
      end else begin
        wait_cnt--;
      end
    end else if (int'($urandom_range(0, 99)) < p_spur) begin
      mem_ready = 1;
      mem_rdata = $urandom;
    end
    if (rel_rst) rst_n = 1;
    #1;
    check("stall", 32'(stall), 32'((i_req & ~m_iack) | ((d_re | d_we) & ~m_dack)));
    model_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_mid_data();
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (m_busy != 2 && guard < 300);
    if (m_busy != 2) begin
      check("rst_wait_timeout", 32'd1, 32'd0);
      return;
    end
    @(posedge clk);
    #2;
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("rst_");
    step();
    step();
    rel_rst = 1;
    step();
    rel_rst = 0;
    run(30);
  endtask

  initial begin
    rst_n = 0; i_req = 0; i_addr = '0; d_re = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 0;
    p_i = 0; p_d = 0; p_both = 0; p_spur = 0; b2b = 0; fixed1 = 0; rel_rst = 0;
    model_reset();
    #2;
    check_outputs("reset_");
    run(2);
    rel_rst = 1;
    step();
    rel_rst = 0;

    // fetch only, fixed address and instruction word
    fixed1 = 1; p_i = 60;
    run(40);
    fixed1 = 0;

    // mixed load/store/fetch traffic
    p_i = 50; p_d = 50;
    run(400);

    // fetch held against back-to-back data requests
    p_i = 100; p_d = 100; b2b = 1;
    run(300);
    b2b = 0;

    // async reset while a data transaction is in flight
    p_i = 60; p_d = 100;
    for (int k = 0; k < 3; k++) reset_mid_data();

    // spurious mem_ready in IDLE and illegal load+store pairs
    p_i = 40; p_d = 50; p_both = 30; p_spur = 30;
    run(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
